// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILL     = 2'd1,
    ARMED    = 2'd2
  } state_t;

  function automatic logic [31:0] len_clamp(input logic [31:0] len,
                                            input logic [31:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_len_cmp.sv
// Masked comparator: true when the low len_i bits of hist_i and pat_i agree.
module seq_len_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               match_o
);

  logic [MAX_LEN-1:0] bit_ok;

  // Bits at or above the active length are don't-care.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_bit
    assign bit_ok[gi] = (len_i <= LEN_W'(gi)) || (hist_i[gi] == pat_i[gi]);
  end

  assign match_o = &bit_ok;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_clr_cnt,
  input  logic               din_valid,
  input  logic               din,
  output logic               flag,
  output logic [CNT_W-1:0]   match_count,
  output logic [1:0]         state
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               flag_q, flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               cmp_eq;
  logic               hit;

  assign len_clamped = LEN_W'(len_clamp(32'(cfg_len), 32'(MAX_LEN)));
  assign hist_shift  = (hist_q << 1) | {{(MAX_LEN-1){1'b0}}, din};
  assign fill_inc    = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;

  // Compare against the post-shift history so the completing bit counts.
  seq_len_cmp #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_cmp (
    .hist_i (hist_shift),
    .pat_i  (pat_q),
    .len_i  (len_q),
    .match_o(cmp_eq)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    flag_d  = 1'b0;
    hit     = 1'b0;

    if (cfg_we) begin
      pat_d   = cfg_pattern;
      len_d   = len_clamped;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = (len_clamped == '0) ? DISABLED : FILL;
    end else if (din_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      hit    = (state_q != DISABLED) && (fill_inc >= len_q) && cmp_eq;
      flag_d = hit;
      if (state_q != DISABLED) begin
        if (hit && !ovl_q) begin
          fill_d  = '0;
          state_d = FILL;
        end else if (fill_inc >= len_q) begin
          state_d = ARMED;
        end else begin
          state_d = FILL;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DISABLED;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flag        = flag_q;
  assign match_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomised and directed check of seq_detect_prog against a queue-based model.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic cfg_overlap = 1'b1;
  logic cfg_clr_cnt = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;

  logic        flag, flag_sat;
  logic [15:0] cnt;
  logic [1:0]  cnt_sat;
  logic [1:0]  state, state_sat;

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_clr_cnt(cfg_clr_cnt),
    .din_valid(din_valid), .din(din), .flag(flag), .match_count(cnt),
    .state(state)
  );

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_clr_cnt(cfg_clr_cnt),
    .din_valid(din_valid), .din(din), .flag(flag_sat), .match_count(cnt_sat),
    .state(state_sat)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Model: bits received since the last clear, newest at the back.
  bit          hq[$];
  int          m_len = 0;
  logic [7:0]  m_pat = '0;
  bit          m_ovl = 1'b1;
  logic        exp_flag = 1'b0;
  int          exp_cnt = 0;
  int          exp_cnt_sat = 0;
  int          exp_state = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_update();
    bit hit = 1'b0;
    if (!rst_n) begin
      m_len = 0; m_pat = '0; m_ovl = 1'b1; hq.delete();
      exp_cnt = 0; exp_cnt_sat = 0;
    end else begin
      if (cfg_we) begin
        m_pat = cfg_pattern;
        m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
        m_ovl = cfg_overlap;
        hq.delete();
      end else if (din_valid) begin
        hq.push_back(din);
        if (hq.size() > MAX_LEN) void'(hq.pop_front());
        if (m_len != 0 && hq.size() >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (hq[hq.size() - 1 - i] != m_pat[i]) hit = 1'b0;
        end
        if (hit && !m_ovl) hq.delete();
      end
      if (cfg_clr_cnt) begin
        exp_cnt = 0; exp_cnt_sat = 0;
      end else if (hit) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt_sat < 3) exp_cnt_sat++;
      end
    end
    exp_flag  = hit;
    exp_state = (m_len == 0) ? 0 : (hq.size() >= m_len) ? 2 : 1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("flag", flag, exp_flag);
      chk("count", cnt, exp_cnt);
      chk("state", state, exp_state);
      chk("sat_flag", flag_sat, exp_flag);
      chk("sat_count", cnt_sat, exp_cnt_sat);
    end
  end

  task automatic step(input logic we, input logic clr, input logic v, input logic d);
    cfg_we = we; cfg_clr_cnt = clr; din_valid = v; din = d;
    @(posedge clk);
    model_update();
    #1;
    cfg_we = 1'b0; cfg_clr_cnt = 1'b0; din_valid = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  logic [6:0] stream = 7'b1101101;
  logic [7:0] fl;
  bit         any_flag;

  initial begin
    // Reset
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    check_en = 1'b1;
    step(0, 0, 1, 1);
    chk("reset_flag", flag, 0);
    chk("reset_count", cnt, 0);
    chk("reset_state", state, 0);
    rst_n = 1'b1;

    // Overlapping detection of 1101 in 1101101
    cfg(8'b1101, 4'd4, 1'b1);
    fl = '0;
    for (int i = 6; i >= 0; i--) begin
      beat(stream[i]);
      fl = {fl[6:0], flag};
    end
    chk("ovl_flags", fl[6:0], 7'b0001001);
    chk("ovl_count", cnt, 2);
    chk("ovl_model_count", exp_cnt, 2);

    // Non-overlapping
    cfg(8'b1101, 4'd4, 1'b0);
    fl = '0;
    for (int i = 6; i >= 0; i--) begin
      beat(stream[i]);
      fl = {fl[6:0], flag};
    end
    chk("novl_flags", fl[6:0], 7'b0001000);
    chk("novl_count", cnt, 1);
    chk("novl_state", state, 1);

    // Invalid-beat gaps between bits
    cfg(8'b1101, 4'd4, 1'b1);
    fl = '0;
    for (int i = 6; i >= 0; i--) begin
      beat(stream[i]);
      fl = {fl[6:0], flag};
      for (int g = 0; g < 2; g++) begin
        step(0, 0, 0, 0);
        chk("gap_flag", flag, 0);
      end
    end
    chk("gap_flags", fl[6:0], 7'b0001001);
    chk("gap_count", cnt, 2);

    // Disabled
    cfg(8'hFF, 4'd0, 1'b1);
    any_flag = 1'b0;
    for (int i = 0; i < 32; i++) begin
      beat(1'($urandom_range(0, 1)));
      any_flag |= flag;
    end
    chk("dis_anyflag", any_flag, 0);
    chk("dis_state", state, 0);

    // Length clamp: 15 behaves as 8
    cfg(8'b10110011, 4'd15, 1'b1);
    fl = '0;
    for (int i = 7; i >= 0; i--) begin
      beat(cfg_pattern[i]);
      fl = {fl[6:0], flag};
    end
    chk("clamp_flags", fl, 8'b00000001);
    chk("clamp_state", state, 2);

    // cfg_we wins over a completing beat
    cfg(8'b1101, 4'd4, 1'b1);
    beat(1); beat(1); beat(0);
    step(1, 0, 1, 1);
    chk("prio_flag", flag, 0);
    chk("prio_state", state, 1);
    chk("prio_hist", u_dut.hist_q, 0);
    beat(1); beat(1); beat(0); beat(1);
    chk("prio_rematch", flag, 1);
    // cfg_clr_cnt wins over a same-cycle increment
    beat(1); beat(0);
    step(0, 1, 1, 1);
    chk("clr_flag", flag, 1);
    chk("clr_count", cnt, 0);

    // Back-to-back and saturation
    cfg(8'b1, 4'd1, 1'b1);
    fl = '0;
    for (int i = 0; i < 5; i++) begin
      beat(1);
      fl = {fl[6:0], flag_sat};
    end
    chk("sat_flags", fl[4:0], 5'b11111);
    chk("sat_hold", cnt_sat, 3);
    chk("sat_wide_count", cnt, 5);

    // Reset mid-fill
    cfg(8'b1101, 4'd4, 1'b1);
    beat(1); beat(1);
    rst_n = 1'b0;
    step(0, 0, 1, 0);
    chk("rst_flag", flag, 0);
    chk("rst_count", cnt, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 4) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = (r == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom_range(0, 1));
        step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 4) begin
        rst_n = 1'b0;
        step(0, 0, 1, 1);
        rst_n = 1'b1;
      end else begin
        step(0, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)));
      end
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Runtime-programmable serial pattern detector, the parametrised successor to the fixed-pattern detector FSM. It sits on a 1-bit serial data path and compares the most recent `cfg_len` valid bits against a programmable pattern of up to `MAX_LEN` bits. It supports overlapping and non-overlapping detection and a saturating match counter. It raises a one-cycle registered `flag` per match for downstream control logic.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits, minimum 2.
- `CNT_W`, default 16: width of the match counter.
- `LEN_W`, default $clog2(MAX_LEN+1): width of the length fields. Derived; do not override.

Ports:
- `clk` in, 1 bit: clock; all logic is on the rising edge.
- `rst_n` in, 1 bit: reset, synchronous, active-low.
- `cfg_we` in, 1 bit: configuration write strobe.
- `cfg_pattern` in, MAX_LEN bits: pattern. Bit `cfg_len-1` is the first bit received and bit 0 is the last.
- `cfg_len` in, LEN_W bits: pattern length. 0 means detection disabled. Values above MAX_LEN are clamped to MAX_LEN.
- `cfg_overlap` in, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping.
- `cfg_clr_cnt` in, 1 bit: clears `match_count`.
- `din_valid` in, 1 bit: `din` is sampled on this cycle.
- `din` in, 1 bit: serial data bit.
- `flag` out, 1 bit: registered match pulse.
- `match_count` out, CNT_W bits: saturating count of matches.
- `state` out, 2 bits: current FSM state, for debug.

## Operation
- **Registers**
  - `pat_q`, `len_q` (clamped value), `ovl_q`.
  - `hist_q[MAX_LEN-1:0]`: shift history; bit 0 is the newest bit.
  - `fill_q`: count of valid history bits, saturates at MAX_LEN.
- **Valid beat** (`din_valid`=1, `cfg_we`=0)
  - `hist_q <= {hist_q[MAX_LEN-2:0], din}`.
  - `fill_q` increments, saturating at MAX_LEN.
- **Match condition**, evaluated on the post-shift history of a valid beat, with all three true:
  - state is not DISABLED;
  - the post-increment fill is ≥ `len_q`;
  - the low `len_q` history bits equal the low `len_q` bits of `pat_q`.
- **On a match**
  - `flag` <= 1 for exactly one cycle.
  - `match_count` increments, saturating at 2^CNT_W-1.
  - If `ovl_q`=0, `fill_q` <= 0, so the matched bits cannot contribute to the next match.
- **FSM**, encoding from the shared package:
  - DISABLED (`len_q`=0): stays here until `cfg_we` writes a nonzero length. `flag` stays 0 and history still shifts.
  - FILL (`fill_q` < `len_q`): moves to ARMED once `fill_q` reaches `len_q`.
  - ARMED: a match is possible on every valid beat. A non-overlapping match returns to FILL.
- **cfg_we**
  - Loads all config fields.
  - Clears `hist_q` and `fill_q`.
  - Next state is DISABLED if the loaded length is 0, otherwise FILL.
  - Has priority over `din_valid` in the same cycle; that `din` bit is discarded and `flag` is 0 that cycle.
- **cfg_clr_cnt**
  - Sets `match_count` <= 0 and has priority over a same-cycle increment.
  - Does not affect detection.
- **Invalid beats**: a cycle with `din_valid`=0 leaves history, fill and state unchanged, and `flag` <= 0.

## Timing
- **Reset values**
  - `flag`=0, `match_count`=0, `state`=DISABLED.
  - `pat_q`=0, `len_q`=0, `ovl_q`=1, `hist_q`=0, `fill_q`=0.
  - Reset has priority over every other input, including mid-fill and mid-match.
- **Latency**: `flag` is high in the cycle after the rising edge that samples the completing bit (one-cycle registered latency).
- **Configuration timing**: the new config is effective for the first valid beat after the `cfg_we` cycle.
- **Back-to-back matches**: with `cfg_len`=1 and overlap, `flag` may be high on consecutive cycles. `flag` never stretches beyond one cycle per match.
- **Counter saturation**: at all-ones, `match_count` holds its value; `flag` still pulses.

## Structure
- Package `seq_detect_pkg`:
  - `state_t` enum: DISABLED=2'd0, FILL=2'd1, ARMED=2'd2.
  - A `len_clamp` function.
- Sub-module `seq_len_cmp`: combinational masked comparator of `hist` and `pat` under `len`, parametrised by MAX_LEN.
- FSM, history, fill counter and match counter stay in the top level.

## Test plan
- **Overlap detection**: reset, then `cfg_we` with pattern 4'b1101, len 4, overlap 1. Drive 1,1,0,1,1,0,1. Required: `flag` pulses after beats 4 and 7, `match_count`=2.
- **Non-overlap detection**: same pattern and stream with overlap 0. Required: a single `flag` after beat 4, `match_count`=1, state returns to FILL.
- **Invalid beats**: insert `din_valid`=0 gaps between the bits of the overlap stream. Required: identical flags relative to valid beats, no flag during gaps.
- **Disable and clamp**:
  - `cfg_len`=0, then drive 32 random bits. Required: `flag` never asserts, state stays DISABLED.
  - `cfg_len`=15 with MAX_LEN=8. Required: behaves as length 8.
- **Config priority**: `cfg_we` coincides with a completing beat. Required: no flag, history cleared, state FILL.
  - `cfg_clr_cnt` coincides with a match. Required: `match_count`=0, `flag`=1.
- **Saturation and reset**:
  - With CNT_W=2, produce 5 matches. Required: count holds at 3.
  - Assert `rst_n`=0 mid-FILL. Required: all outputs return to their reset values on the next edge.
